// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the ID/EXE stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    // Register-file address width shared with the rest of the pipeline
    localparam int REG_FILE_ADDR_LEN = 5;

    // Cycles a multiply occupies EXE, issue cycle included
    localparam int DEFAULT_MUL_LAT = 4;

    // Sequencer states: IDLE handles single-cycle hazards, MUL_RUN holds EXE
    typedef enum logic {
        HAZ_IDLE    = 1'b0,
        HAZ_MUL_RUN = 1'b1
    } haz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare between the ID sources and a load sitting in EXE.
// Latency: combinational, zero cycles.
// Backpressure: none; the result only feeds stall decisions.
module hazard_detect_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN
) (
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_r_en,
    output logic                  load_use
);

    // Register 0 is hard-wired, so a load targeting it can never create a hazard
    always_comb begin
        load_use = exe_mem_r_en && (exe_dest != '0) &&
                   ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer around ID/EXE: multiply occupancy, load-use, branch flush.
// Latency: controls are combinational from state and inputs; state updates next edge.
// Backpressure: freezes hold PC/IF/ID/ID-EXE while a multiply runs or a load-use resolves.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT    = DEFAULT_MUL_LAT,
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_r_en,
    input  logic                  exe_mul_en,
    input  logic                  exe_br_taken,
    output logic                  pc_freeze,
    output logic                  ifid_freeze,
    output logic                  ifid_flush,
    output logic                  idexe_freeze,
    output logic                  idexe_flush,
    output logic                  exe_bubble,
    output logic                  mul_busy,
    output logic [CNT_W-1:0]      stall_cnt
);

    haz_state_t state;
    logic [3:0] cnt;
    logic       load_use;

    hazard_detect_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_mem_r_en (exe_mem_r_en),
        .load_use     (load_use)
    );

    // Priority: multiply start/run, then taken branch, then load-use; reset silences all
    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idexe_freeze = 1'b0;
        idexe_flush  = 1'b0;
        exe_bubble   = 1'b0;
        mul_busy     = (state == HAZ_MUL_RUN);
        if (!rst) begin
            if (state == HAZ_IDLE) begin
                if (exe_mul_en) begin
                    pc_freeze    = 1'b1;
                    ifid_freeze  = 1'b1;
                    idexe_freeze = 1'b1;
                    exe_bubble   = 1'b1;
                end else if (exe_br_taken) begin
                    // The ID instruction is squashed, so its load-use hazard is moot
                    ifid_flush  = 1'b1;
                    idexe_flush = 1'b1;
                end else if (load_use) begin
                    pc_freeze   = 1'b1;
                    ifid_freeze = 1'b1;
                    idexe_flush = 1'b1;
                end
            end else if (cnt != 4'd0) begin
                pc_freeze    = 1'b1;
                ifid_freeze  = 1'b1;
                idexe_freeze = 1'b1;
                exe_bubble   = 1'b1;
            end
        end
    end

    // Multiply sequencer: cnt counts the remaining frozen cycles after the issue cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HAZ_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                HAZ_IDLE: begin
                    if (exe_mul_en) begin
                        cnt   <= 4'(MUL_LAT - 2);
                        state <= HAZ_MUL_RUN;
                    end
                end
                HAZ_MUL_RUN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= HAZ_IDLE;
                    end
                end
                default: begin
                    state <= HAZ_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Saturating count of PC-freeze cycles for performance debug
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pc_freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized check of pipe_hazard_ctrl against an occupancy-based model.
// Latency: model predicts combinational outputs each cycle, counters after each edge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_src1, id_src2, exe_dest;
    logic       id_two_src, exe_mem_r_en, exe_mul_en, exe_br_taken;

    logic        pc_freeze, ifid_freeze, ifid_flush, idexe_freeze, idexe_flush, exe_bubble, mul_busy;
    logic [31:0] stall_cnt;

    logic        s_pc_freeze, s_ifid_freeze, s_ifid_flush, s_idexe_freeze, s_idexe_flush, s_exe_bubble, s_mul_busy;
    logic [3:0]  s_stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // Model state: cycles of multiply occupancy still ahead (0 = EXE free)
    int          occ_left = 0;
    longint      m_stalls = 0;
    int          m_stalls4 = 0;
    logic        obs_bubble;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en), .exe_mul_en(exe_mul_en),
        .exe_br_taken(exe_br_taken), .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze),
        .ifid_flush(ifid_flush), .idexe_freeze(idexe_freeze), .idexe_flush(idexe_flush),
        .exe_bubble(exe_bubble), .mul_busy(mul_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .REG_ADDR_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en), .exe_mul_en(exe_mul_en),
        .exe_br_taken(exe_br_taken), .pc_freeze(s_pc_freeze), .ifid_freeze(s_ifid_freeze),
        .ifid_flush(s_ifid_flush), .idexe_freeze(s_idexe_freeze), .idexe_flush(s_idexe_flush),
        .exe_bubble(s_exe_bubble), .mul_busy(s_mul_busy), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic r, input logic mul, input logic br, input logic ld,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic two);
        rst = r; exe_mul_en = mul; exe_br_taken = br; exe_mem_r_en = ld;
        exe_dest = d; id_src1 = s1; id_src2 = s2; id_two_src = two;
    endtask

    // One cycle: predict outputs from the hazard rules, compare mid-cycle, then advance the model
    task automatic tick(input string tag);
        logic lu, stall, ifl, ifz, idz, idl, bub, busy;
        @(negedge clk);
        lu = exe_mem_r_en && exe_dest != 0 &&
             (exe_dest == id_src1 || (id_two_src && exe_dest == id_src2));
        {stall, ifz, ifl, idz, idl, bub} = '0;
        busy = (occ_left > 0);
        if (!rst) begin
            if (occ_left == 0 && exe_mul_en) {stall, ifz, idz, bub} = '1;
            else if (occ_left > 1)           {stall, ifz, idz, bub} = '1;
            else if (occ_left == 0 && exe_br_taken) {ifl, idl} = '1;
            else if (occ_left == 0 && lu)    {stall, ifz, idl} = '1;
        end
        obs_bubble = exe_bubble;
        chk({tag, "_ctrl"}, {pc_freeze, ifid_freeze, ifid_flush, idexe_freeze, idexe_flush, exe_bubble, mul_busy},
            {stall, ifz, ifl, idz, idl, bub, busy});
        chk({tag, "_cnt"}, stall_cnt, m_stalls);
        chk({tag, "_cnt4"}, s_stall_cnt, m_stalls4);
        chk({tag, "_idexe_excl"}, idexe_freeze & idexe_flush, 0);
        chk({tag, "_ifid_excl"}, ifid_freeze & ifid_flush, 0);
        @(posedge clk);
        if (rst) begin
            occ_left = 0; m_stalls = 0; m_stalls4 = 0;
        end else begin
            if (stall) begin
                m_stalls++;
                if (m_stalls4 < 15) m_stalls4++;
            end
            if (occ_left > 0) occ_left--;
            else if (exe_mul_en) occ_left = MUL_LAT - 1;
        end
        #1;
    endtask

    initial begin
        longint base;
        int     zero_bub;

        // Reset held with a multiply request pending: everything stays quiet
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick("rst0");
        tick("rst1");
        chk("rst_busy", mul_busy, 0);
        chk("rst_cnt", stall_cnt, 0);

        // Release: the pending multiply freezes immediately, then runs to completion
        rst = 0;
        for (int i = 0; i < MUL_LAT; i++) tick("mul1");
        exe_mul_en = 0;
        chk("mul1_stalls", stall_cnt, 3);
        tick("mul1_after");

        // Load-use variants
        drive(0, 0, 0, 1, 5, 5, 0, 0);  tick("lu_src1");
        exe_mem_r_en = 0;               tick("lu_cleared");
        drive(0, 0, 0, 1, 0, 0, 0, 0);  tick("lu_r0");
        drive(0, 0, 0, 1, 5, 3, 5, 0);  tick("lu_src2_unused");
        id_two_src = 1;                 tick("lu_src2_used");
        exe_mem_r_en = 0;               tick("lu_src2_cleared");

        // Taken branch masks a matching load-use
        drive(0, 0, 1, 1, 5, 5, 0, 0);  tick("br_lu");
        chk("br_pc_freeze", pc_freeze, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  tick("br_after");

        // Back-to-back multiplies: two results, six stall cycles
        base = stall_cnt;
        zero_bub = 0;
        exe_mul_en = 1;
        for (int i = 0; i < 2 * MUL_LAT; i++) begin
            tick("b2b");
            if (obs_bubble == 1'b0) zero_bub++;
        end
        exe_mul_en = 0;
        chk("b2b_stalls", stall_cnt - base, 6);
        chk("b2b_results", zero_bub, 2);
        tick("b2b_after");

        // Reset arriving while the multiply has one frozen cycle left
        exe_mul_en = 1;
        tick("mid_start");
        tick("mid_run");
        rst = 1;
        tick("mid_rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick("mid_after");
        chk("mid_busy", mul_busy, 0);

        // Twenty stall cycles: narrow counter pins at its maximum
        drive(0, 0, 0, 1, 7, 7, 0, 0);
        for (int i = 0; i < 20; i++) tick("sat");
        chk("sat_value", s_stall_cnt, 15);

        // Random traffic with narrow register range to force frequent matches
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(59) == 0, $urandom_range(5) == 0, $urandom_range(4) == 0,
                  $urandom_range(1) == 1, 5'($urandom_range(3)), 5'($urandom_range(3)),
                  5'($urandom_range(3)), $urandom_range(1) == 1);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline around the ID/EXE pipeline register.
- Handles three events: multi-cycle multiply occupancy of EXE, load-use hazards between ID and EXE, and taken-branch flushes.
- Drives freeze/flush controls to the PC, IF/ID and ID/EXE registers, plus a bubble-insert control for EXE/MEM.
- Keeps a stall-cycle counter for performance debug.

Parameters:
- MUL_LAT, 4, cycles a multiply occupies EXE, including the issue cycle; legal range 2..16.
- REG_ADDR_W, 5, register-file address width (matches the shared REG_FILE_ADDR_LEN).
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_src1  in  REG_ADDR_W  source 1 of the instruction in ID.
- id_src2  in  REG_ADDR_W  source 2 of the instruction in ID.
- id_two_src  in  1  the ID instruction reads id_src2.
- exe_dest  in  REG_ADDR_W  destination register of the instruction in EXE.
- exe_mem_r_en  in  1  the EXE instruction is a load.
- exe_mul_en  in  1  the EXE instruction is a multiply (MUL_EN_OUT of the ID/EXE register).
- exe_br_taken  in  1  branch resolved taken in EXE.
- pc_freeze  out  1  hold the PC.
- ifid_freeze  out  1  hold the IF/ID register.
- ifid_flush  out  1  zero the IF/ID register.
- idexe_freeze  out  1  hold the ID/EXE register.
- idexe_flush  out  1  load a bubble (all enables 0) into ID/EXE.
- exe_bubble  out  1  force WB_EN, MEM_R_EN and MEM_W_EN to 0 into EXE/MEM.
- mul_busy  out  1  FSM is in MUL_RUN.
- stall_cnt  out  CNT_W  total cycles with pc_freeze=1.

Behaviour:
- FSM states: IDLE and MUL_RUN. Internal down-counter cnt is 4 bits wide.
- Outputs are combinational from state, cnt and inputs. State, cnt and stall_cnt are registered.
- Reset:
  - state=IDLE, cnt=0, stall_cnt=0.
  - With all inputs at 0, every output reads 0.
  - Reset in mid-run returns the FSM to IDLE on the next edge and drops all freezes.
- IDLE, exe_mul_en=1 (multiply start, highest priority):
  - pc_freeze, ifid_freeze, idexe_freeze and exe_bubble are all 1.
  - cnt <= MUL_LAT-2; next state MUL_RUN.
  - exe_br_taken and load-use are ignored this cycle.
- MUL_RUN, cnt!=0:
  - The same four outputs are 1; cnt decrements.
- MUL_RUN, cnt==0:
  - Final multiply cycle. All freezes are 0 and exe_bubble=0, so the result passes to EXE/MEM.
  - Next state IDLE.
- Multiply occupancy:
  - A multiply occupies EXE for exactly MUL_LAT cycles and emits exactly one write-back.
  - A back-to-back multiply enters IDLE with exe_mul_en=1 and restarts the sequence with no gap cycle.
- IDLE, exe_mul_en=0, exe_br_taken=1 (taken branch):
  - ifid_flush=1 and idexe_flush=1; no freeze.
  - Load-use detection is masked, because the ID instruction is being squashed.
- IDLE, exe_mul_en=0, exe_br_taken=0, load-use:
  - Load-use condition: exe_mem_r_en=1, exe_dest!=0, and either exe_dest==id_src1 or (id_two_src=1 and exe_dest==id_src2).
  - Response: pc_freeze=1, ifid_freeze=1, idexe_flush=1 for one cycle. The bubble advances the load, so the condition clears by itself.
- A freeze and a flush on the same register never assert together:
  - idexe_freeze and idexe_flush are mutually exclusive.
  - ifid_freeze and ifid_flush are mutually exclusive.
- Register 0 never causes a hazard.
- stall_cnt increments on every clock edge where pc_freeze=1. It saturates at all-ones and never wraps.
- During MUL_RUN, exe_mul_en and exe_dest are stable because ID/EXE is frozen. The FSM ignores exe_mul_en while in MUL_RUN.

Decomposition:
- Shared defines file additions:
  - FSM state encodings HAZ_IDLE=1'b0 and HAZ_MUL_RUN=1'b1.
  - Default MUL_LAT.
  - Reuse of the existing REG_FILE_ADDR_LEN.
- One sub-module: hazard_detect_unit, purely combinational, computing the load-use compare. It is reusable by a future forwarding unit.
- The FSM, cnt and stall_cnt stay in the top module.
- Companion change: the ID/EXE and IF/ID registers gain freeze and flush inputs, with freeze taking priority after rst.

Test Plan:
1. Reset: assert rst for 2 cycles with exe_mul_en=1 → all outputs 0, stall_cnt=0, mul_busy=0. Release → freeze asserts on the first cycle.
2. Single multiply, MUL_LAT=4: pulse exe_mul_en at cycle 0 and hold it while frozen → pc_freeze/idexe_freeze/exe_bubble are 1 for cycles 0-2 and 0 at cycle 3. mul_busy is 1 for cycles 1-3. stall_cnt=3.
3. Load-use: exe_mem_r_en=1, exe_dest=5, id_src1=5 → pc_freeze=1 and idexe_flush=1 for one cycle. Repeat with exe_dest=0 → no stall. Repeat with id_src2=5 and id_two_src=0 → no stall.
4. Branch plus load-use: exe_br_taken=1 with a matching load-use condition → ifid_flush=1, idexe_flush=1, pc_freeze=0.
5. Back-to-back multiplies: two multiplies, MUL_LAT=4 → 8 EXE cycles, stall_cnt=6, exactly two cycles with exe_bubble=0.
6. Mid-run reset and saturation: rst during MUL_RUN with cnt=1 → IDLE next cycle, all outputs 0. Separately, with CNT_W=4, force 20 stall cycles → stall_cnt holds at 15.
